// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: FPU operation sequencer, steps each request through
// DEC -> EXEC -> ENC and reports done or error (illegal op / abort / timeout).
// Optional stage watchdog enabled by defining FPU_SEQ_WDOG_EN.

// Per-lane execute gating: enable only the selected lane while in EXEC and
// only let the selected lane's ready through.
module fpu_seq_lane (
  input  logic op_sel,
  input  logic in_exec,
  input  logic ready,
  output logic mod_en,
  output logic hit
);
  assign mod_en = op_sel & in_exec;
  assign hit    = op_sel & ready;
endmodule

module fpu_seq_ctrl #(
  parameter int NUM_OPS     = 7,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               fpu_clk,
  input  logic               fpu_rst_n,
  input  logic               fpu_en_i,
  input  logic [NUM_OPS-1:0] fpu_op_i,
  input  logic               fpu_dec_ready_i,
  input  logic [NUM_OPS-1:0] fpu_mod_ready_i,
  input  logic               fpu_enc_ready_i,
  output logic               fpu_dec_en_o,
  output logic [NUM_OPS-1:0] fpu_mod_en_o,
  output logic               fpu_enc_en_o,
  output logic               fpu_busy_o,
  output logic               fpu_done_o,
  output logic               fpu_err_o,
  output logic [1:0]         fpu_err_code_o,
  output logic [CNT_W-1:0]   fpu_op_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_EXEC, S_ENC, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t             state_q, state_d;
  logic [NUM_OPS-1:0] op_q, op_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_inc;
  logic               op_onehot;
  logic               in_exec;
  logic               wdog_to;
  logic [NUM_OPS-1:0] lane_hit;

  assign op_onehot = (fpu_op_i != '0) && ((fpu_op_i & (fpu_op_i - 1'b1)) == '0);
  assign in_exec   = (state_q == S_EXEC);

  genvar k;
  generate
    for (k = 0; k < NUM_OPS; k++) begin : g_lane
      fpu_seq_lane u_lane (
        .op_sel  (op_q[k]),
        .in_exec (in_exec),
        .ready   (fpu_mod_ready_i[k]),
        .mod_en  (fpu_mod_en_o[k]),
        .hit     (lane_hit[k])
      );
    end
  endgenerate

`ifdef FPU_SEQ_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_q;
  logic              stage_busy;

  assign stage_busy = (state_q == S_DEC) || (state_q == S_EXEC) || (state_q == S_ENC);
  assign wdog_to    = stage_busy && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog: cycles spent in the current busy stage, cleared on any state change.
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n)                              wdog_q <= '0;
    else if (!stage_busy || state_d != state_q)  wdog_q <= '0;
    else                                         wdog_q <= wdog_q + 1'b1;
  end
`else
  assign wdog_to = 1'b0;
`endif

  // State, latched opcode, error code and completed-op counter.
  always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
    if (!fpu_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next state: abort beats ready, ready beats timeout.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = ERR_NONE;
        if (fpu_en_i) begin
          if (op_onehot) begin
            op_d    = fpu_op_i;
            state_d = S_DEC;
          end else begin
            err_d   = ERR_ILLEGAL;
            state_d = S_ERR;
          end
        end
      end
      S_DEC: begin
        if (!fpu_en_i)            begin state_d = S_ERR; err_d = ERR_ABORT;   end
        else if (fpu_dec_ready_i)       state_d = S_EXEC;
        else if (wdog_to)         begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_EXEC: begin
        if (!fpu_en_i)            begin state_d = S_ERR; err_d = ERR_ABORT;   end
        else if (|lane_hit)             state_d = S_ENC;
        else if (wdog_to)         begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_ENC: begin
        if (!fpu_en_i)            begin state_d = S_ERR; err_d = ERR_ABORT;   end
        else if (fpu_enc_ready_i) begin state_d = S_DONE; cnt_inc = 1'b1;     end
        else if (wdog_to)         begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_DONE: begin
        if (!fpu_en_i) state_d = S_IDLE;
      end
      S_ERR: begin
        if (!fpu_en_i) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = ERR_NONE;
      end
    endcase
  end

  // Moore output decode.
  always_comb begin
    fpu_dec_en_o   = (state_q == S_DEC);
    fpu_enc_en_o   = (state_q == S_ENC);
    fpu_busy_o     = (state_q == S_DEC) || (state_q == S_EXEC) || (state_q == S_ENC);
    fpu_done_o     = (state_q == S_DONE);
    fpu_err_o      = (state_q == S_ERR);
    fpu_err_code_o = err_q;
    fpu_op_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed testbench for fpu_seq_ctrl (WDOG_CYCLES=8, optional FPU_SEQ_WDOG_EN).
module tb_fpu_seq_ctrl;
  localparam int NOPS = 7;
  localparam int CW   = 16;

  logic            fpu_clk = 1'b0;
  logic            fpu_rst_n;
  logic            fpu_en_i;
  logic [NOPS-1:0] fpu_op_i;
  logic            fpu_dec_ready_i;
  logic [NOPS-1:0] fpu_mod_ready_i;
  logic            fpu_enc_ready_i;
  logic            fpu_dec_en_o;
  logic [NOPS-1:0] fpu_mod_en_o;
  logic            fpu_enc_en_o;
  logic            fpu_busy_o;
  logic            fpu_done_o;
  logic            fpu_err_o;
  logic [1:0]      fpu_err_code_o;
  logic [CW-1:0]   fpu_op_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt = '0;

  always #5 fpu_clk = ~fpu_clk;

  fpu_seq_ctrl #(.NUM_OPS(NOPS), .CNT_W(CW), .WDOG_CYCLES(8)) dut (
    .fpu_clk(fpu_clk), .fpu_rst_n(fpu_rst_n), .fpu_en_i(fpu_en_i), .fpu_op_i(fpu_op_i),
    .fpu_dec_ready_i(fpu_dec_ready_i), .fpu_mod_ready_i(fpu_mod_ready_i),
    .fpu_enc_ready_i(fpu_enc_ready_i), .fpu_dec_en_o(fpu_dec_en_o),
    .fpu_mod_en_o(fpu_mod_en_o), .fpu_enc_en_o(fpu_enc_en_o), .fpu_busy_o(fpu_busy_o),
    .fpu_done_o(fpu_done_o), .fpu_err_o(fpu_err_o), .fpu_err_code_o(fpu_err_code_o),
    .fpu_op_cnt_o(fpu_op_cnt_o)
  );

  task automatic tick;
    @(posedge fpu_clk); #1;
  endtask

  // Packs every output into one word: {dec,mod[6:0],enc,busy,done,err,code[1:0]}
  function automatic logic [13:0] outs();
    return {fpu_dec_en_o, fpu_mod_en_o, fpu_enc_en_o, fpu_busy_o, fpu_done_o,
            fpu_err_o, fpu_err_code_o};
  endfunction

  task automatic test_reset;
    fpu_rst_n = 1'b0; fpu_en_i = 1'b0; fpu_op_i = '0;
    fpu_dec_ready_i = 1'b0; fpu_mod_ready_i = '0; fpu_enc_ready_i = 1'b0;
    #12;
    n_checks++;
    if (outs() !== 14'h0 || fpu_op_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_outs: got %h cnt %h, want 0 cnt 0", outs(), fpu_op_cnt_o);
    end
    fpu_rst_n = 1'b1;
    tick;
    n_checks++;
    if (outs() !== 14'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h want 0", outs());
    end
  endtask

  // Full operation with ready delays dd/md/ed (cycles waited before ready).
  task automatic test_lane(input int k, input int dd, input int md, input int ed);
    logic [NOPS-1:0] op;
    op = NOPS'(1) << k;
    fpu_en_i = 1'b1; fpu_op_i = op;
    tick;
    fpu_op_i = ~op;  // must be ignored after IDLE exit
    for (int i = 0; i < dd; i++) begin
      n_checks++;
      if (!(fpu_dec_en_o === 1'b1 && fpu_busy_o === 1'b1 && fpu_mod_en_o === '0)) begin
        n_fail++; $display("FAIL lane%0d_dec: dec %b busy %b mod %b, want 1 1 0", k,
                           fpu_dec_en_o, fpu_busy_o, fpu_mod_en_o);
      end
      tick;
    end
    fpu_dec_ready_i = 1'b1; tick; fpu_dec_ready_i = 1'b0;
    for (int i = 0; i <= md; i++) begin
      n_checks++;
      if (fpu_mod_en_o !== op || fpu_dec_en_o !== 1'b0) begin
        n_fail++; $display("FAIL lane%0d_exec: mod %b dec %b, want %b 0", k,
                           fpu_mod_en_o, fpu_dec_en_o, op);
      end
      if (i < md) tick;
    end
    fpu_mod_ready_i = op; tick; fpu_mod_ready_i = '0;
    for (int i = 0; i <= ed; i++) begin
      n_checks++;
      if (fpu_enc_en_o !== 1'b1 || fpu_mod_en_o !== '0) begin
        n_fail++; $display("FAIL lane%0d_enc: enc %b mod %b, want 1 0", k,
                           fpu_enc_en_o, fpu_mod_en_o);
      end
      if (i < ed) tick;
    end
    fpu_enc_ready_i = 1'b1; tick; fpu_enc_ready_i = 1'b0;
    exp_cnt++;
    n_checks++;
    if (fpu_done_o !== 1'b1 || fpu_busy_o !== 1'b0 || fpu_op_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL lane%0d_done: done %b busy %b cnt %0d, want 1 0 %0d", k,
                         fpu_done_o, fpu_busy_o, fpu_op_cnt_o, exp_cnt);
    end
    tick;  // DONE holds while en is high
    n_checks++;
    if (fpu_done_o !== 1'b1) begin
      n_fail++; $display("FAIL lane%0d_done_hold: done %b want 1", k, fpu_done_o);
    end
    fpu_en_i = 1'b0; fpu_op_i = '0; tick;
    n_checks++;
    if (outs() !== 14'h0) begin
      n_fail++; $display("FAIL lane%0d_idle: got %h want 0", k, outs());
    end
  endtask

  task automatic test_illegal(input logic [NOPS-1:0] op);
    fpu_en_i = 1'b1; fpu_op_i = op; tick;
    n_checks++;
    if (fpu_err_o !== 1'b1 || fpu_err_code_o !== 2'b01 || fpu_dec_en_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_%b: err %b code %b dec %b, want 1 01 0", op,
                         fpu_err_o, fpu_err_code_o, fpu_dec_en_o);
    end
    tick;
    n_checks++;
    if (fpu_err_o !== 1'b1 || fpu_dec_en_o !== 1'b0) begin
      n_fail++; $display("FAIL illegal_hold_%b: err %b dec %b, want 1 0", op, fpu_err_o, fpu_dec_en_o);
    end
    fpu_en_i = 1'b0; fpu_op_i = '0; tick;
    n_checks++;
    if (outs() !== 14'h0) begin
      n_fail++; $display("FAIL illegal_idle_%b: got %h want 0", op, outs());
    end
  endtask

  task automatic test_wrong_lane_ready;
    fpu_en_i = 1'b1; fpu_op_i = 7'b000_1000; tick;
    fpu_enc_ready_i = 1'b1;  // stale ready in DEC, must be ignored later
    fpu_dec_ready_i = 1'b1; tick; fpu_dec_ready_i = 1'b0; fpu_enc_ready_i = 1'b0;
    fpu_mod_ready_i = 7'b000_0100;
    tick; tick;
    n_checks++;
    if (fpu_mod_en_o !== 7'b000_1000 || fpu_enc_en_o !== 1'b0) begin
      n_fail++; $display("FAIL wrong_lane_stay: mod %b enc %b, want 0001000 0",
                         fpu_mod_en_o, fpu_enc_en_o);
    end
    fpu_mod_ready_i = 7'b000_1000; tick; fpu_mod_ready_i = '0;
    n_checks++;
    if (fpu_enc_en_o !== 1'b1 || fpu_mod_en_o !== '0) begin
      n_fail++; $display("FAIL wrong_lane_enc: enc %b mod %b, want 1 0", fpu_enc_en_o, fpu_mod_en_o);
    end
    tick;
    n_checks++;
    if (fpu_enc_en_o !== 1'b1 || fpu_done_o !== 1'b0) begin
      n_fail++; $display("FAIL stale_enc_ready: enc %b done %b, want 1 0", fpu_enc_en_o, fpu_done_o);
    end
    fpu_enc_ready_i = 1'b1; tick; fpu_enc_ready_i = 1'b0;
    exp_cnt++;
    n_checks++;
    if (fpu_done_o !== 1'b1 || fpu_op_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL wrong_lane_done: done %b cnt %0d, want 1 %0d", fpu_done_o,
                         fpu_op_cnt_o, exp_cnt);
    end
    fpu_en_i = 1'b0; tick;
  endtask

  // All readys held high: DEC, EXEC, ENC one cycle each, then DONE.
  task automatic test_latency;
    fpu_dec_ready_i = 1'b1; fpu_mod_ready_i = '1; fpu_enc_ready_i = 1'b1;
    fpu_en_i = 1'b1; fpu_op_i = 7'b100_0000;
    tick;
    n_checks++;
    if (fpu_dec_en_o !== 1'b1) begin
      n_fail++; $display("FAIL lat_dec: dec %b want 1", fpu_dec_en_o);
    end
    tick;
    n_checks++;
    if (fpu_mod_en_o !== 7'b100_0000) begin
      n_fail++; $display("FAIL lat_exec: mod %b want 1000000", fpu_mod_en_o);
    end
    tick;
    n_checks++;
    if (fpu_enc_en_o !== 1'b1) begin
      n_fail++; $display("FAIL lat_enc: enc %b want 1", fpu_enc_en_o);
    end
    tick;
    exp_cnt++;
    n_checks++;
    if (fpu_done_o !== 1'b1 || fpu_op_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL lat_done: done %b cnt %0d, want 1 %0d", fpu_done_o, fpu_op_cnt_o, exp_cnt);
    end
    fpu_en_i = 1'b0; fpu_dec_ready_i = 1'b0; fpu_mod_ready_i = '0; fpu_enc_ready_i = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    fpu_en_i = 1'b1; fpu_op_i = 7'b000_0001; tick;
    fpu_dec_ready_i = 1'b1; tick; fpu_dec_ready_i = 1'b0;
    fpu_en_i = 1'b0; fpu_mod_ready_i = 7'b000_0001;  // abort beats ready
    tick; fpu_mod_ready_i = '0;
    n_checks++;
    if (fpu_err_o !== 1'b1 || fpu_err_code_o !== 2'b10 || fpu_mod_en_o !== '0 ||
        fpu_enc_en_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_err: err %b code %b mod %b enc %b, want 1 10 0 0",
                         fpu_err_o, fpu_err_code_o, fpu_mod_en_o, fpu_enc_en_o);
    end
    tick;
    n_checks++;
    if (outs() !== 14'h0 || fpu_op_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL abort_idle: got %h cnt %0d, want 0 cnt %0d", outs(), fpu_op_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_enc;
    fpu_en_i = 1'b1; fpu_op_i = 7'b001_0000; tick;
    fpu_dec_ready_i = 1'b1; tick; fpu_dec_ready_i = 1'b0;
    fpu_mod_ready_i = 7'b001_0000; tick; fpu_mod_ready_i = '0;
    n_checks++;
    if (fpu_enc_en_o !== 1'b1 || fpu_op_cnt_o === 16'h0) begin
      n_fail++; $display("FAIL pre_reset_enc: enc %b cnt %0d, want 1 nonzero", fpu_enc_en_o, fpu_op_cnt_o);
    end
    #2 fpu_rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    n_checks++;
    if (outs() !== 14'h0 || fpu_op_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL async_reset: got %h cnt %0d, want 0 cnt 0", outs(), fpu_op_cnt_o);
    end
    fpu_en_i = 1'b0; fpu_op_i = '0;
    #1 fpu_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_watchdog;
    fpu_en_i = 1'b1; fpu_op_i = 7'b000_0010; tick;
`ifdef FPU_SEQ_WDOG_EN
    for (int i = 0; i < 7; i++) tick;
    n_checks++;
    if (fpu_dec_en_o !== 1'b1 || fpu_err_o !== 1'b0) begin
      n_fail++; $display("FAIL wdog_dec8: dec %b err %b, want 1 0", fpu_dec_en_o, fpu_err_o);
    end
    tick;
    n_checks++;
    if (fpu_err_o !== 1'b1 || fpu_err_code_o !== 2'b11 || fpu_dec_en_o !== 1'b0) begin
      n_fail++; $display("FAIL wdog_timeout: err %b code %b dec %b, want 1 11 0",
                         fpu_err_o, fpu_err_code_o, fpu_dec_en_o);
    end
    fpu_en_i = 1'b0; tick;
`else
    for (int i = 0; i < 99; i++) tick;
    n_checks++;
    if (fpu_dec_en_o !== 1'b1 || fpu_err_o !== 1'b0) begin
      n_fail++; $display("FAIL no_wdog_dec100: dec %b err %b, want 1 0", fpu_dec_en_o, fpu_err_o);
    end
    fpu_en_i = 1'b0; tick;
    n_checks++;
    if (fpu_err_code_o !== 2'b10) begin
      n_fail++; $display("FAIL no_wdog_abort: code %b want 10", fpu_err_code_o);
    end
    tick;
`endif
    n_checks++;
    if (outs() !== 14'h0) begin
      n_fail++; $display("FAIL wdog_idle: got %h want 0", outs());
    end
  endtask

  initial begin
    test_reset;
    for (int k = 0; k < NOPS; k++) test_lane(k, 3, 2, 5);
    test_illegal(7'b000_0000);
    test_illegal(7'b001_0100);
    test_wrong_lane_ready;
    test_latency;
    test_abort;
    test_reset_mid_enc;
    test_watchdog;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200us");
    $fatal(1);
  end
endmodule
